// File: rtl/poly_byte_encode12.sv
// poly_byte_encode12: packs 12-bit coefficients (4 per beat) into the ByteEncode_12 stream
// through a 48-to-64-bit gearbox, one polynomial per run.
module poly_byte_encode12 #(
   parameter int N = 256
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [47:0] i_coeffs,
   input  logic        i_coeffs_valid,
   output logic        o_coeffs_ready,
   output logic [63:0] o_obytes,
   output logic        o_obytes_valid,
   input  logic        i_obytes_ready,
   output logic        o_done
);
   localparam int BEATS = N / 4;
   localparam int WORDS = 3 * N / 16;
   localparam int IW = $clog2(BEATS + 1);
   localparam int OW = $clog2(WORDS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nx;
   logic [127:0]    buffer, shifted, placed;
   logic [3:0]      fill, wpos;
   logic [IW-1:0]   in_cnt;
   logic [OW-1:0]   out_cnt;
   logic [47:0]     packed_beat;
   logic            push, pop, last_pop;

   // each coefficient pair (c0, c1) becomes c0[7:0], {c1[3:0], c0[11:8]}, c1[11:4]
   assign packed_beat = {i_coeffs[43:36], i_coeffs[27:24], i_coeffs[47:44], i_coeffs[35:28],
                         i_coeffs[19:12], i_coeffs[3:0],   i_coeffs[23:20], i_coeffs[11:4]};

   assign o_obytes       = buffer[127:64];
   assign o_obytes_valid = (fill >= 4'd4);
   assign o_coeffs_ready = (fill <= 4'd5) && (in_cnt < IW'(BEATS)) && (state != DONE);
   assign o_done         = (state == DONE);

   assign push     = i_coeffs_valid && o_coeffs_ready;
   assign pop      = o_obytes_valid && i_obytes_ready;
   assign last_pop = pop && (out_cnt == OW'(WORDS - 1));

   // shift out the popped word first, then drop the new beat right after the remaining fill
   assign shifted = pop ? {buffer[63:0], 64'd0} : buffer;
   assign wpos    = pop ? fill - 4'd4 : fill;
   assign placed  = {packed_beat, 80'd0} >> {wpos, 4'd0};

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == IDLE && push)
         state_nx = RUN;
      else if (state == RUN && last_pop)
         state_nx = DONE;
      else if (state == DONE)
         state_nx = IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         buffer  <= '0;
         fill    <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else if (state == DONE) begin
         buffer  <= '0;
         fill    <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         buffer  <= push ? (shifted | placed) : shifted;
         fill    <= fill + (push ? 4'd3 : 4'd0) - (pop ? 4'd4 : 4'd0);
         in_cnt  <= in_cnt + IW'(push);
         out_cnt <= out_cnt + OW'(pop);
      end
   end
endmodule

// File: tb/tb_poly_byte_encode12.sv
// tb_poly_byte_encode12: scoreboard bench; expected bytes come from an arithmetic
// ByteEncode_12 model queued at beat acceptance and popped by an output monitor.
module tb_poly_byte_encode12;
   localparam int N = 256;
   localparam int BEATS = N / 4;
   localparam int WORDS = 3 * N / 16;

   logic        clk = 0;
   logic        rstn = 1;
   logic [47:0] coeffs = '0;
   logic        cvalid = 0;
   logic        cready;
   logic [63:0] obytes;
   logic        ovalid;
   logic        oready = 0;
   logic        done;

   int checks = 0, errors = 0, rmode = 0, ndone = 0, wcnt = 0, n_acc = 0;
   logic [7:0]  q[$];
   logic [63:0] got[$];
   bit          last_pop_prev = 0, hold_prev = 0;
   logic [63:0] hold_word = '0;
   int          grp[4] = '{'h123, 'h456, 'h789, 'hABC};

   poly_byte_encode12 #(.N(N)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_coeffs(coeffs), .i_coeffs_valid(cvalid),
      .o_coeffs_ready(cready), .o_obytes(obytes), .o_obytes_valid(ovalid),
      .i_obytes_ready(oready), .o_done(done)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #2;
      oready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(99) < 60);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // reference ByteEncode_12 on coefficient pairs, plain arithmetic
   task automatic push_model(input int c[4]);
      for (int p = 0; p < 2; p++) begin
         q.push_back(8'(c[2*p] % 256));
         q.push_back(8'(c[2*p] / 256 + (c[2*p+1] % 16) * 16));
         q.push_back(8'(c[2*p+1] / 16));
      end
   endtask

   task automatic send_beat(input int c[4], input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
      coeffs = {12'(c[0]), 12'(c[1]), 12'(c[2]), 12'(c[3])};
      cvalid = 1;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (cready) break;
         t++;
         if (t > 2000) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no ready expected ready within 2000 cycles");
            @(posedge clk);
            #1;
            cvalid = 0;
            return;
         end
      end
      push_model(c);
      n_acc++;
      @(posedge clk);
      #1;
      cvalid = 0;
   endtask

   task automatic send_poly(input int kind, input int nb, input int first, input int gapmax);
      int c[4];
      for (int b = first; b < first + nb; b++) begin
         for (int k = 0; k < 4; k++)
            c[k] = (kind == 0) ? 4 * b + k : (kind == 1) ? grp[k] : int'($urandom_range(4095));
         send_beat(c, (gapmax > 0) ? int'($urandom_range(gapmax)) : 0);
      end
   endtask

   task automatic wait_done(input int target);
      int t = 0;
      while (ndone < target && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("done_count", 64'(ndone), 64'(target));
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         last_pop_prev = 0;
         hold_prev = 0;
      end else begin
         logic [63:0] exp;
         chk("done_pulse", 64'(done), 64'(last_pop_prev));
         if (done) ndone++;
         last_pop_prev = 0;
         if (hold_prev) begin
            chk("hold_valid", 64'(ovalid), 64'd1);
            chk("hold_data", obytes, hold_word);
         end
         if (ovalid && oready) begin
            if (q.size() < 8) begin
               checks++;
               errors++;
               $display("FAIL word_underflow: got word %h expected no word", obytes);
            end else begin
               exp = '0;
               for (int i = 0; i < 8; i++) exp = {exp[55:0], q.pop_front()};
               chk("word", obytes, exp);
            end
            got.push_back(obytes);
            wcnt++;
            if (wcnt == WORDS) begin
               wcnt = 0;
               last_pop_prev = 1;
            end
         end
         hold_prev = ovalid && !oready;
         hold_word = obytes;
      end
   end

   initial begin
      int c[4];
      int t;
      #1 rstn = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_obytes", obytes, 64'd0);
      chk("rst_ovalid", 64'(ovalid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ready", 64'(cready), 64'd1);
      @(posedge clk);
      #1 rstn = 1;

      // single group of known coefficients
      rmode = 0;
      got.delete();
      send_poly(1, 4, 0, 0);
      repeat (6) @(posedge clk);
      #1;
      chk("grp_w0", got[0], 64'h2361_4589_C7AB_2361);
      chk("grp_w1", got[1], 64'h4589_C7AB_2361_4589);
      chk("grp_w2", got[2], 64'hC7AB_2361_4589_C7AB);
      send_poly(2, BEATS - 4, 1, 0);
      wait_done(1);
      chk("idle_ready", 64'(cready), 64'd1);
      chk("idle_valid", 64'(ovalid), 64'd0);

      // full polynomial, coefficient i = i
      got.delete();
      send_poly(0, BEATS, 0, 0);
      wait_done(2);
      chk("idx_w0", got[0], 64'h0010_0002_3000_0450);
      chk("idx_words", 64'(got.size()), 64'(WORDS));

      // consumer stalled from the start
      rmode = 1;
      got.delete();
      n_acc = 0;
      fork
         send_poly(1, BEATS, 0, 0);
      join_none
      repeat (10) @(negedge clk);
      chk("bp_beats", 64'(n_acc), 64'd2);
      chk("bp_ready", 64'(cready), 64'd0);
      chk("bp_valid", 64'(ovalid), 64'd1);
      chk("bp_data", obytes, 64'h2361_4589_C7AB_2361);
      rmode = 0;
      wait fork;
      wait_done(3);
      chk("bp_words", 64'(got.size()), 64'(WORDS));

      // random valid/ready over three polynomials
      rmode = 2;
      for (int p = 0; p < 3; p++) begin
         send_poly(2, BEATS, 0, 3);
         wait_done(4 + p);
      end

      // raw 0xFFF packing, then a beat offered past the end
      rmode = 0;
      got.delete();
      c = '{'hFFF, 0, 'h5A5, 'h0F0};
      send_beat(c, 0);
      send_poly(2, BEATS - 1, 1, 0);
      for (int k = 0; k < 4; k++) c[k] = int'($urandom_range(4095));
      coeffs = {12'(c[0]), 12'(c[1]), 12'(c[2]), 12'(c[3])};
      cvalid = 1;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (cready || t > 200) break;
         t++;
      end
      chk("extra_after_done", 64'(ndone), 64'd7);
      chk("extra_stalled", 64'(t > 0), 64'd1);
      push_model(c);
      @(posedge clk);
      #1;
      cvalid = 0;
      chk("raw_b0", 64'(got[0][63:56]), 64'hFF);
      chk("raw_b1_lo", 64'(got[0][51:48]), 64'hF);

      // reset in the middle of a run
      send_poly(2, 19, 1, 0);
      rstn = 0;
      #1;
      chk("mid_rst_obytes", obytes, 64'd0);
      chk("mid_rst_ovalid", 64'(ovalid), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_ready", 64'(cready), 64'd1);
      q.delete();
      wcnt = 0;
      @(posedge clk);
      #1 rstn = 1;
      got.delete();
      rmode = 2;
      send_poly(2, BEATS, 0, 2);
      wait_done(8);
      chk("post_rst_words", 64'(got.size()), 64'(WORDS));
      chk("post_rst_queue", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
